// File: rtl/pipelined_delay_unit.sv
// Per-channel DEPTH-stage bubble-collapsing register pipeline with optional output crossover.
// Latency DEPTH cycles; ready to each input is combinational through a full pipe, so a pop frees a slot the same cycle.
module pipelined_delay_unit #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 3,
    parameter int CROSS    = 1
) (
    input  logic                                    CLK,
    input  logic                                    RESET,
    input  logic [CHANNELS*WIDTH-1:0]               INPUT_data,
    input  logic [CHANNELS-1:0]                     INPUT_valid,
    output logic [CHANNELS-1:0]                     INPUT_ready,
    output logic [CHANNELS*WIDTH-1:0]               OUTPUT_data,
    output logic [CHANNELS-1:0]                     OUTPUT_valid,
    input  logic [CHANNELS-1:0]                     OUTPUT_ready,
    output logic [CHANNELS*$clog2(DEPTH+1)-1:0]     OCCUPANCY
);

    localparam int OW = $clog2(DEPTH + 1);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam int DST = (CROSS != 0) ? (CHANNELS - 1 - c) : c;

        logic [DEPTH-1:0] r_vld;
        logic [WIDTH-1:0] r_dat [DEPTH];
        logic [OW-1:0]    r_occ;
        logic [DEPTH-1:0] w_take;
        logic             w_pop;
        logic             w_push;

        // A stage takes its predecessor's contents when it is empty or its own
        // contents move on this cycle; the chain starts at the output pop.
        always_comb begin : p_take
            logic w_adv;
            w_take = '0;
            w_pop  = r_vld[DEPTH-1] & OUTPUT_ready[DST];
            w_adv  = w_pop;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                w_take[k] = ~r_vld[k] | w_adv;
                w_adv     = w_take[k];
            end
            w_push = INPUT_valid[c] & w_take[0] & ~RESET;
        end

        always_ff @(posedge CLK) begin
            if (RESET) begin
                r_vld <= '0;
                r_occ <= '0;
                for (int k = 0; k < DEPTH; k++) begin
                    r_dat[k] <= '0;
                end
            end else begin
                if (w_take[0]) begin
                    r_vld[0] <= w_push;
                    r_dat[0] <= INPUT_data[c*WIDTH +: WIDTH];
                end
                for (int k = 1; k < DEPTH; k++) begin
                    if (w_take[k]) begin
                        r_vld[k] <= r_vld[k-1];
                        r_dat[k] <= r_dat[k-1];
                    end
                end
                if (w_push && !w_pop) begin
                    r_occ <= r_occ + OW'(1);
                end else if (!w_push && w_pop) begin
                    r_occ <= r_occ - OW'(1);
                end
            end
        end

        assign INPUT_ready[c]                    = w_take[0] & ~RESET;
        assign OUTPUT_valid[DST]                 = r_vld[DEPTH-1];
        assign OUTPUT_data[DST*WIDTH +: WIDTH]   = r_dat[DEPTH-1];
        assign OCCUPANCY[c*OW +: OW]             = r_occ;
    end

endmodule

// File: doc/pipelined_delay_unit.md
PIPELINED_DELAY_UNIT -- requirements
Module: pipelined_delay_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the data bits per channel.
REQ-002 The block SHALL have parameter CHANNELS, default 2, giving the number of independent ready/valid channels (>=1).
REQ-003 The block SHALL have parameter DEPTH, default 3, giving the pipeline stages per channel (>=1).
REQ-004 The block SHALL have parameter CROSS, default 1; 1 = input i routed to output CHANNELS-1-i, 0 = input i routed to output i.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high; ports CLK and RESET.
REQ-006 CLK  input  1  rising-edge clock for all state.
REQ-007 RESET  input  1  synchronous active-high reset.
REQ-008 INPUT_data  input  CHANNELS*WIDTH  channel i in bits [i*WIDTH +: WIDTH].
REQ-009 INPUT_valid  input  CHANNELS  per-channel producer valid.
REQ-010 INPUT_ready  output  CHANNELS  per-channel acceptance.
REQ-011 OUTPUT_data  output  CHANNELS*WIDTH  channel j in bits [j*WIDTH +: WIDTH].
REQ-012 OUTPUT_valid  output  CHANNELS  per-channel output valid.
REQ-013 OUTPUT_ready  input  CHANNELS  per-channel consumer ready.
REQ-014 OCCUPANCY  output  CHANNELS*clog2(DEPTH+1)  beats in flight per input channel i.

Function
REQ-015 Each channel SHALL be an independent DEPTH-stage register pipeline; stage k holds a valid bit and WIDTH data bits.
REQ-016 A transfer SHALL occur on any interface in a cycle where valid and ready are both 1 at the rising CLK edge.
REQ-017 Stage k SHALL load from stage k-1 (stage 0 from INPUT) when stage k is empty or stage k advances in the same cycle (bubble-collapsing).
REQ-018 The last stage of input channel i SHALL drive OUTPUT_valid/OUTPUT_data of output channel CROSS ? CHANNELS-1-i : i.
REQ-019 INPUT_ready[i] SHALL be 1 when stage 0 of channel i is empty or advances this cycle, combinationally including a same-cycle output pop through a full pipeline.
REQ-020 Latency SHALL be exactly DEPTH cycles from input acceptance to OUTPUT_valid with no stall; throughput 1 beat/cycle/channel.
REQ-021 OUTPUT_valid and OUTPUT_data SHALL remain stable while OUTPUT_valid=1 and OUTPUT_ready=0.
REQ-022 Beats SHALL leave a channel in acceptance order with data unmodified; no beat dropped or duplicated.
REQ-023 With output stalled, a channel SHALL accept exactly DEPTH beats, then hold INPUT_ready=0 until a pop.
REQ-024 OCCUPANCY[i] SHALL increment on push only, decrement on pop only, hold on simultaneous push+pop; range 0..DEPTH.
REQ-025 Channels SHALL NOT interact: a stall on one channel SHALL NOT affect timing of another.
REQ-026 DEPTH=1 SHALL give latency 1 and full-rate pass-through with combinational ready from OUTPUT_ready.

Reset
REQ-027 While RESET=1 at a CLK edge, all stage valid bits SHALL clear, data registers SHALL load 0, OCCUPANCY SHALL be 0.
REQ-028 While RESET=1, INPUT_ready SHALL be 0 and no input SHALL be accepted; OUTPUT_valid SHALL be 0 the cycle after reset is sampled.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; none SHALL appear after RESET deasserts.

Verification (WIDTH=5, CHANNELS=2, DEPTH=3, CROSS=1 unless stated)
REQ-030 Push 5'h0A on channel 0 at cycle 0, OUTPUT_ready=2'b11 -> OUTPUT_valid[1]=1 with data 5'h0A at cycle 3, OUTPUT_valid[0] stays 0.
REQ-031 OUTPUT_ready[0]=0, stream 5'h01..5'h04 on channel 1 -> three accepted, INPUT_ready[1]=0, OCCUPANCY[1]=3, OUTPUT_data[0] held 5'h01; raise ready -> 01,02,03,04 out on consecutive cycles.
REQ-032 Full channel 0 with OUTPUT_ready[1]=1 and continuous input -> INPUT_ready[0] stays 1, OCCUPANCY[0] stays 3, one beat out per cycle.
REQ-033 Two beats in flight on channel 0, assert RESET one cycle -> OCCUPANCY=0, OUTPUT_valid=2'b00, no beat emitted afterwards.
REQ-034 CROSS=0, DEPTH=1: push 5'h1F on channel 1 -> OUTPUT_valid[1]=1, data 5'h1F one cycle later; OUTPUT_valid[0]=0.
REQ-035 Random valid/ready on both channels for 10000 cycles -> scoreboard shows in-order, lossless delivery per channel; stability property of REQ-021 never violated.
